// File: rtl/clk_div_bank_pkg.sv
// Shared types and helpers for the clock-divider bank.
package clk_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int unsigned CNT_W_DEFAULT = 32;

    // Select-field width that stays legal for a single-channel bank.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Channel enables, sync, configuration port and per-channel outputs of the bank.
interface clk_div_bank_if
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
);
    localparam int unsigned CH_W = clog2_min1(NUM_CH);

    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;

    modport master (
        output ch_en, sync, cfg_we, cfg_ch, cfg_div, cfg_mode,
        input  clk_out, tick, pend
    );

    modport slave (
        input  ch_en, sync, cfg_we, cfg_ch, cfg_div, cfg_mode,
        output clk_out, tick, pend
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: wrap counter, shadow/active divisor and mode, pending flag.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned DIV_RST  = 355500,
    parameter mode_e       MODE_RST = MODE_TOGGLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] div_i,
    input  mode_e            mode_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             pend_o
);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] sdiv_q, sdiv_d;
    mode_e            mode_q, mode_d;
    mode_e            smode_q, smode_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= DIV_INIT;
            sdiv_q  <= DIV_INIT;
            mode_q  <= MODE_RST;
            smode_q <= MODE_RST;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sdiv_q  <= sdiv_d;
            mode_q  <= mode_d;
            smode_q <= smode_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    // A write in the same cycle as a transfer is folded into the shadow first,
    // so the new value goes active on that edge and pend ends cleared.
    always_comb begin
        sdiv_d  = wr_i ? div_i : sdiv_q;
        smode_d = wr_i ? mode_i : smode_q;
        pend_d  = pend_q | wr_i;
        cnt_d   = cnt_q;
        div_d   = div_q;
        mode_d  = mode_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        xfer    = 1'b0;
        if (sync_i || !en_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            xfer  = 1'b1;
        end else if (div_q == '0) begin
            cnt_d = '0;
        end else if (cnt_q == div_q - ONE) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            xfer   = 1'b1;
            clk_d  = (smode_d == MODE_PULSE) ? 1'b1 : ~clk_q;
        end else begin
            cnt_d = cnt_q + ONE;
            if (mode_q == MODE_PULSE) clk_d = 1'b0;
        end
        if (xfer) begin
            div_d  = sdiv_d;
            mode_d = smode_d;
            pend_d = 1'b0;
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable divider channels sharing one configuration port.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned DIV_RST  = 355500,
    parameter bit          MODE_RST = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    clk_div_bank_if.slave bus
);
    localparam int unsigned CH_W = clog2_min1(NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        // Out-of-range selects match no channel and are dropped.
        assign wr = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W    (CNT_W),
            .DIV_RST  (DIV_RST),
            .MODE_RST (mode_e'(MODE_RST))
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (bus.ch_en[i]),
            .sync_i    (bus.sync),
            .wr_i      (wr),
            .div_i     (bus.cfg_div),
            .mode_i    (mode_e'(bus.cfg_mode)),
            .clk_out_o (bus.clk_out[i]),
            .tick_o    (bus.tick[i]),
            .pend_o    (bus.pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised and directed checks of clk_div_bank against a period-level reference model.
module tb_clk_div_bank;
    import clk_div_pkg::*;

    localparam int unsigned NCH  = 3;
    localparam int unsigned CW   = 8;
    localparam int unsigned DRST = 40;
    localparam int unsigned CHW  = clog2_min1(NCH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clk_div_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    clk_div_bank #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .DIV_RST  (DRST),
        .MODE_RST (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks cycles elapsed in the current period per channel.
    int unsigned m_div[NCH], m_sdiv[NCH], m_el[NCH];
    bit m_mode[NCH], m_smode[NCH], m_pend[NCH], m_clk[NCH], m_tick[NCH];

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_div[c] = DRST; m_sdiv[c] = DRST; m_mode[c] = 0; m_smode[c] = 0;
            m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0; m_el[c] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int c = 0; c < NCH; c++) begin
            if (bus.cfg_we && int'(bus.cfg_ch) == c) begin
                m_sdiv[c] = bus.cfg_div; m_smode[c] = bus.cfg_mode; m_pend[c] = 1;
            end
            m_tick[c] = 0;
            if (bus.sync || !bus.ch_en[c]) begin
                m_el[c] = 0; m_clk[c] = 0;
                m_div[c] = m_sdiv[c]; m_mode[c] = m_smode[c]; m_pend[c] = 0;
            end else if (m_div[c] != 0) begin
                m_el[c]++;
                if (m_el[c] == m_div[c]) begin
                    m_el[c] = 0; m_tick[c] = 1;
                    m_div[c] = m_sdiv[c]; m_mode[c] = m_smode[c]; m_pend[c] = 0;
                    m_clk[c] = m_mode[c] ? 1'b1 : !m_clk[c];
                end else if (m_mode[c]) begin
                    m_clk[c] = 0;
                end
            end
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    logic [NCH-1:0] ec, et, ep;
    initial forever begin
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            ec[c] = m_clk[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
        end
        check("model_clk_out", bus.clk_out, ec);
        check("model_tick", bus.tick, et);
        check("model_pend", bus.pend, ep);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic sig(input int sel, input int c);
        case (sel)
            0:       return bus.clk_out[c];
            1:       return bus.tick[c];
            default: return bus.pend[c];
        endcase
    endfunction

    task automatic wait_bit(input int sel, input int c, input logic val, input int maxc, output int k);
        k = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (sig(sel, c) === val) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic cfg_write(input int c, input int div, input logic mode);
        bus.cfg_we = 1'b1; bus.cfg_ch = CHW'(c); bus.cfg_div = CW'(div); bus.cfg_mode = mode;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic count_ones(input int sel, input int c, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sig(sel, c) === 1'b1) cnt++;
        end
    endtask

    initial begin
        int k, n, n2, flips;
        int first[NCH];
        logic prev;

        bus.ch_en = '0; bus.sync = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_ch = '0; bus.cfg_div = '0; bus.cfg_mode = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_clk_out", bus.clk_out, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_pend", bus.pend, 0);
        rst_n = 1'b1;
        @(negedge clk);

        bus.ch_en = 3'b001;
        wait_bit(0, 0, 1'b1, 100, k);
        check("first_toggle", k, DRST);
        wait_bit(0, 0, 1'b0, 100, k);
        check("second_toggle", k, DRST);

        cfg_write(1, 5, 1'b1);
        check("pend_while_disabled", bus.pend[1], 0);
        bus.ch_en = 3'b011;
        wait_bit(1, 1, 1'b1, 20, k);
        check("pulse_first_tick", k, 5);
        count_ones(1, 1, 50, n);
        check("pulse_tick_count", n, 10);

        cfg_write(2, 10, 1'b0);
        bus.ch_en = 3'b111;
        wait_bit(0, 2, 1'b1, 30, k);
        check("div10_rise", k, 10);
        repeat (3) @(negedge clk);
        cfg_write(2, 3, 1'b0);
        check("pend_mid_period", bus.pend[2], 1);
        wait_bit(0, 2, 1'b0, 30, k);
        check("old_half_period", k, 6);
        check("pend_after_wrap", bus.pend[2], 0);
        wait_bit(0, 2, 1'b1, 30, k);
        check("new_half_period", k, 3);

        cfg_write(2, 1, 1'b0);
        repeat (5) @(negedge clk);
        flips = 0;
        prev = bus.clk_out[2];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.clk_out[2] !== prev) flips++;
            prev = bus.clk_out[2];
        end
        check("div1_toggle_flips", flips, 6);

        cfg_write(1, 1, 1'b1);
        repeat (8) @(negedge clk);
        count_ones(1, 1, 10, n);
        check("div1_pulse_tick", n, 10);

        cfg_write(0, 0, 1'b0);
        wait_bit(2, 0, 1'b0, 100, k);
        check("div0_xfer_seen", (k > 0) ? 1 : 0, 1);
        prev = bus.clk_out[0];
        count_ones(1, 0, 100, n);
        check("div0_no_ticks", n, 0);
        check("div0_clk_frozen", bus.clk_out[0], prev);

        cfg_write(0, 9, 1'b0);
        check("div0_pend_stuck", bus.pend[0], 1);
        cfg_write(1, 6, 1'b1);
        repeat ($urandom_range(0, 7)) @(negedge clk);
        bus.sync = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_ch = '0; bus.cfg_div = CW'(4); bus.cfg_mode = 1'b0;
        @(negedge clk);
        bus.sync = 1'b0; bus.cfg_we = 1'b0;
        check("sync_clk_out", bus.clk_out, 0);
        check("sync_tick", bus.tick, 0);
        check("sync_pend", bus.pend, 0);
        for (int c = 0; c < NCH; c++) first[c] = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++)
                if (first[c] < 0 && bus.tick[c] === 1'b1) first[c] = i;
        end
        check("sync_tick_ch0", first[0], 4);
        check("sync_tick_ch1", first[1], 6);
        check("sync_tick_ch2", first[2], 1);

        bus.ch_en = 3'b011;
        cfg_write(2, 255, 1'b1);
        bus.ch_en = 3'b111;
        wait_bit(1, 2, 1'b1, 300, k);
        check("max_div_first_tick", k, 255);
        wait_bit(1, 2, 1'b1, 300, k);
        check("max_div_period", k, 255);

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                int b = $urandom_range(0, NCH - 1);
                bus.ch_en[b] = ~bus.ch_en[b];
            end
            bus.sync     = ($urandom_range(0, 63) == 0);
            bus.cfg_we   = ($urandom_range(0, 7) == 0);
            bus.cfg_ch   = CHW'($urandom_range(0, 3));
            bus.cfg_div  = CW'($urandom_range(0, 12));
            bus.cfg_mode = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.sync = 1'b0; bus.cfg_we = 1'b0; bus.ch_en = 3'b111;
        repeat (20) @(negedge clk);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_clk_out", bus.clk_out, 0);
        check("async_rst_tick", bus.tick, 0);
        check("async_rst_pend", bus.pend, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.ch_en = 3'b001;
        cfg_write(NCH, 2, 1'b1);
        check("bad_ch_pend", bus.pend, 0);
        wait_bit(1, 0, 1'b1, 60, k);
        check("bad_ch_ignored", k, DRST - 1);
        check("bad_ch_others", bus.tick[2:1], 0);

        bus.ch_en = '0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable clock-enable and divided-clock generator. Successor to the fixed single-output divider.
- Each of NUM_CH channels has a runtime-programmable divisor, a mode (toggle or pulse), an enable and a pending-update flag.
- Divisor updates are glitch-free: they pass through a shadow register.
- Outputs feed LED/display scan logic and peripheral tick enables in the same clock domain.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 32, counter and divisor width.
- DIV_RST, 355500, active and shadow divisor value of every channel after reset.
- MODE_RST, 0, mode of every channel after reset (0 = toggle, 1 = pulse).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_en  in  NUM_CH  per-channel enable.
- sync  in  1  single-cycle request to restart all channels in phase.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel select for a write.
- cfg_div  in  CNT_W  new divisor.
- cfg_mode  in  1  new mode.
- clk_out  out  NUM_CH  registered divided outputs (toggle mode: square wave; pulse mode: one-cycle tick).
- tick  out  NUM_CH  registered one-cycle strobe on every wrap event, in either mode.
- pend  out  NUM_CH  1 = shadow configuration written but not yet active.

Behaviour:
- Reset (async, rst_n = 0):
  - cnt = 0; clk_out = 0; tick = 0; pend = 0.
  - Active and shadow divisor = DIV_RST; active and shadow mode = MODE_RST.
- Counting, for a channel with ch_en = 1 and active div D >= 1:
  - cnt increments each cycle.
  - When cnt == D-1: cnt <- 0 and a wrap event occurs (tick = 1 for the following cycle).
  - First tick is D cycles after the first edge that samples ch_en = 1.
- Toggle mode: clk_out inverts on each wrap event; period 2*D cycles, 50% duty.
- Pulse mode: clk_out = tick; period D cycles, high for 1 cycle.
- D = 1:
  - Pulse mode: clk_out and tick constantly 1.
  - Toggle mode: clk_out = clk/2.
- D = 0: channel stalls. cnt held at 0, tick = 0, clk_out holds its value. pend semantics unchanged.
- Compare uses full CNT_W width with no overflow. D = 2^CNT_W-1 is legal. cnt never exceeds D-1.
- ch_en = 0:
  - Next edge: cnt <- 0, clk_out <- 0, tick <- 0.
  - Any pending shadow copies to active immediately and pend clears.
- Configuration write (cfg_we = 1):
  - Shadow of cfg_ch <- cfg_div/cfg_mode; pend[cfg_ch] <- 1.
  - cfg_ch >= NUM_CH: write ignored.
- Shadow to active transfer happens at:
  - the wrap event of an enabled channel (new D governs the next period);
  - while the channel is disabled;
  - on sync.
  - The transfer clears pend in the same cycle.
- Write coinciding with a wrap or sync on the same channel: new value is written to shadow and transferred in that same edge; pend ends 0.
- Mode change from toggle to pulse on transfer: clk_out follows pulse rule from the next cycle.
- sync = 1: all channels get cnt <- 0, clk_out <- 0, tick <- 0, shadow transferred. This takes precedence over the counting of that cycle.
- Simultaneous sync and ch_en = 0: same result, since both clear.
- rst_n asserted mid-period: immediate return to reset values. Counting restarts from 0 after the first edge with rst_n = 1.

Decomposition:
- Package clk_div_pkg:
  - mode constants MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1;
  - CNT_W default;
  - function clog2_min1.
- Sub-module clk_div_chan: one channel's counter, shadow/active registers, mode logic and pend.
- clk_div_bank generates NUM_CH instances and decodes cfg_we/cfg_ch into per-channel write strobes.

Test Plan:
- Reset value check: hold rst_n = 0 and check reset values. Release, ch_en = 4'b0001, defaults → clk_out[0] first toggles 355500 cycles after enable, then every 355500 cycles.
- Pulse mode: write ch1 div = 5, mode = 1, enable → tick[1] and clk_out[1] high exactly 1 of every 5 cycles, first tick 5 cycles after enable.
- Glitch-free update: ch2 div = 10 toggle running; write div = 3 mid-period → pend[2] = 1 until the next wrap. Current half-period stays 10 cycles, subsequent half-periods are 3 cycles, pend[2] = 0.
- Edge divisors: div = 1 toggle → clk_out = clk/2. div = 1 pulse → tick constant 1. div = 0 → no ticks over 100 cycles and clk_out frozen.
- sync behaviour: channels with div 4 and 6 at arbitrary phase; pulse sync → all cnt 0, outputs 0. Next ticks at +4 and +6 cycles. Coincident cfg_we on ch0 applied with pend[0] = 0.
- Async reset mid-run: assert rst_n between edges → outputs 0 immediately (no clock edge). Write to cfg_ch = NUM_CH → no state change.
